// File: rtl/adat_pkg.sv
// ADAT framing constants, payload/state types and the payload-to-frame mapping.
// Latency: pure combinational helper, no state.
// Backpressure: n/a (shared by encoder RTL and receiver-side benches).
package adat_pkg;

  localparam int ADAT_FRAME_BITS  = 256;
  localparam int ADAT_SYNC_ZEROS  = 10;
  localparam int ADAT_CHANNELS    = 8;
  localparam int ADAT_SAMPLE_BITS = 24;
  localparam int ADAT_USER_BITS   = 4;

  // Each sample is sent as 6 nibbles, every nibble preceded by a '1' separator.
  localparam int ADAT_NIBBLES   = ADAT_SAMPLE_BITS / 4;
  localparam int ADAT_CHAN_BITS = ADAT_NIBBLES * 5;
  localparam int ADAT_HDR_BITS  = ADAT_SYNC_ZEROS + 2 + ADAT_USER_BITS;

  // samples[ADAT_CHANNELS-1] is ch0, so a flat 192-bit bus maps straight onto it.
  typedef struct packed {
    logic [ADAT_USER_BITS-1:0]                        user;
    logic [ADAT_CHANNELS-1:0][ADAT_SAMPLE_BITS-1:0]   samples;
  } adat_payload_t;

  typedef enum logic {
    StIdle,
    StRunning
  } encoder_state_e;

  // Returns the frame with bit index i (line order) at vector position i.
  function automatic logic [ADAT_FRAME_BITS-1:0] adat_frame_bits(input adat_payload_t p);
    logic [ADAT_FRAME_BITS-1:0]  f;
    logic [ADAT_SAMPLE_BITS-1:0] s;
    int                          base;
    f = '0;
    f[ADAT_SYNC_ZEROS]     = 1'b1;
    f[ADAT_SYNC_ZEROS + 1] = 1'b1;
    for (int k = 0; k < ADAT_USER_BITS; k++) begin
      f[ADAT_SYNC_ZEROS + 2 + k] = p.user[ADAT_USER_BITS - 1 - k];
    end
    for (int c = 0; c < ADAT_CHANNELS; c++) begin
      s = p.samples[ADAT_CHANNELS - 1 - c];
      for (int n = 0; n < ADAT_NIBBLES; n++) begin
        base    = ADAT_HDR_BITS + ADAT_CHAN_BITS * c + 5 * n;
        f[base] = 1'b1;
        for (int j = 0; j < 4; j++) begin
          f[base + 1 + j] = s[ADAT_SAMPLE_BITS - 1 - 4 * n - j];
        end
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/adat_frame_shifter.sv
// 256-bit frame shift register: loads a whole frame, then presents one bit per tick.
// Latency: on a load tick the frame's bit 0 is presented combinationally; later bits follow one per tick.
// Backpressure: none, advances only on i_tick.
module adat_frame_shifter
  import adat_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_tick,
  input  logic                       i_load,
  input  logic [ADAT_FRAME_BITS-1:0] i_frame,
  output logic                       o_bit
);

  logic [ADAT_FRAME_BITS-1:0] r_sr;

  // Bit 0 goes out straight from i_frame on the load tick, so the register keeps bits 1..255.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr <= '0;
    end else if (i_tick) begin
      if (i_load) begin
        r_sr <= {1'b0, i_frame[ADAT_FRAME_BITS-1:1]};
      end else begin
        r_sr <= {1'b0, r_sr[ADAT_FRAME_BITS-1:1]};
      end
    end
  end

  assign o_bit = i_load ? i_frame[0] : r_sr[0];

endmodule

// File: rtl/adat_nrzi_frame_encoder.sv
// ADAT transmitter: double-buffered payload in, NRZI line out at one bit per 4 clk_x4_i cycles.
// Latency: accepted payload starts (bit 0) on the first bit tick after the shadow is full, <= 5 cycles.
// Backpressure: frame_ready_o is low while the shadow holds a frame; it frees at the next frame boundary.
module adat_nrzi_frame_encoder
  import adat_pkg::*;
#(
  parameter bit UNDERRUN_REPEAT = 1'b0,
  parameter bit INIT_LEVEL      = 1'b0
) (
  input  logic                                     clk_x4_i,
  input  logic                                     rst_i,
  input  logic [ADAT_CHANNELS*ADAT_SAMPLE_BITS-1:0] samples_i,
  input  logic [ADAT_USER_BITS-1:0]                user_i,
  input  logic                                     frame_valid_i,
  output logic                                     frame_ready_o,
  output logic                                     nrzi_o,
  output logic                                     bit_tick_o,
  output logic                                     frame_start_o,
  output logic                                     underrun_o,
  output logic                                     active_o
);

  logic [1:0]     r_div;
  encoder_state_e r_state;
  logic [7:0]     r_bit_idx;
  logic           r_nrzi;
  logic           r_ready;
  adat_payload_t  r_shadow;
  adat_payload_t  r_last;

  logic                       w_tick;
  logic                       w_full;
  logic                       w_xfer;
  logic                       w_frame_edge;
  logic                       w_consume;
  logic                       w_underrun;
  logic                       w_bit;
  adat_payload_t              w_payload_in;
  adat_payload_t              w_src;
  logic [ADAT_FRAME_BITS-1:0] w_frame;

  assign w_tick       = (r_div == 2'b11);
  assign w_full       = ~r_ready;
  assign w_xfer       = frame_valid_i & r_ready;
  assign w_payload_in = {user_i, samples_i};

  // A frame boundary is the tick that emits bit 0: the idle start, or every 256th running tick.
  assign w_frame_edge = w_tick & (((r_state == StIdle) & w_full) |
                                  ((r_state == StRunning) & (r_bit_idx == 8'd0)));
  assign w_consume    = w_frame_edge & w_full;
  assign w_underrun   = w_tick & (r_state == StRunning) & (r_bit_idx == 8'd0) & ~w_full;

  // Payload for the frame starting now: fresh shadow, else silence or a repeat of the last frame.
  always_comb begin
    w_src = adat_payload_t'('0);
    if (w_full) begin
      w_src = r_shadow;
    end else if (UNDERRUN_REPEAT) begin
      w_src = r_last;
    end
  end

  assign w_frame = adat_frame_bits(w_src);

  // Free-running bit-rate divider; it never stops so the tick grid is fixed from reset.
  always_ff @(posedge clk_x4_i) begin
    if (rst_i) begin
      r_div <= 2'b00;
    end else begin
      r_div <= r_div + 2'd1;
    end
  end

  // Shadow buffer: fill on handshake, free again once the boundary tick has taken the frame.
  always_ff @(posedge clk_x4_i) begin
    if (rst_i) begin
      r_ready  <= 1'b1;
      r_shadow <= '0;
    end else if (w_xfer) begin
      r_ready  <= 1'b0;
      r_shadow <= w_payload_in;
    end else if (w_consume) begin
      r_ready  <= 1'b1;
    end
  end

  // Frame sequencer and NRZI line: start on the first tick with a full shadow, then one bit per tick forever.
  always_ff @(posedge clk_x4_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_bit_idx <= 8'd0;
      r_nrzi    <= INIT_LEVEL;
      r_last    <= '0;
    end else if (w_tick) begin
      if (w_frame_edge) begin
        r_last <= w_src;
      end
      case (r_state)
        StIdle: begin
          if (w_full) begin
            r_state   <= StRunning;
            r_bit_idx <= 8'd1;
            r_nrzi    <= r_nrzi ^ w_bit;
          end
        end
        StRunning: begin
          r_bit_idx <= r_bit_idx + 8'd1;
          r_nrzi    <= r_nrzi ^ w_bit;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  adat_frame_shifter u_shifter (
    .i_clk   (clk_x4_i),
    .i_rst   (rst_i),
    .i_tick  (w_tick),
    .i_load  (w_frame_edge),
    .i_frame (w_frame),
    .o_bit   (w_bit)
  );

  assign frame_ready_o = r_ready;
  assign nrzi_o        = r_nrzi;
  assign bit_tick_o    = w_tick;
  assign frame_start_o = w_frame_edge;
  assign underrun_o    = w_underrun;
  assign active_o      = (r_state == StRunning);

endmodule

// File: tb/tb_adat_nrzi_frame_encoder.sv
// Bench for the ADAT NRZI encoder: two instances (silence / repeat on underrun, INIT_LEVEL 0 / 1).
// A negedge monitor predicts line level, ticks, ready, frame_start and underrun from a frame-level model.
// Stimulus: directed payloads, randomized payloads and gaps, starvation and a mid-frame reset.
module tb_adat_nrzi_frame_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         valid;
  logic [191:0] samples;
  logic [3:0]   user;

  logic ready0, nrzi0, tick0, fs0, urun0, act0;
  logic ready1, nrzi1, tick1, fs1, urun1, act1;

  adat_nrzi_frame_encoder #(.UNDERRUN_REPEAT(1'b0), .INIT_LEVEL(1'b0)) dut0 (
    .clk_x4_i(clk), .rst_i(rst), .samples_i(samples), .user_i(user),
    .frame_valid_i(valid), .frame_ready_o(ready0), .nrzi_o(nrzi0),
    .bit_tick_o(tick0), .frame_start_o(fs0), .underrun_o(urun0), .active_o(act0)
  );

  adat_nrzi_frame_encoder #(.UNDERRUN_REPEAT(1'b1), .INIT_LEVEL(1'b1)) dut1 (
    .clk_x4_i(clk), .rst_i(rst), .samples_i(samples), .user_i(user),
    .frame_valid_i(valid), .frame_ready_o(ready1), .nrzi_o(nrzi1),
    .bit_tick_o(tick1), .frame_start_o(fs1), .underrun_o(urun1), .active_o(act1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame built by appending fields in transmission order.
  function automatic logic [255:0] ref_frame(input logic [191:0] s, input logic [3:0] u);
    bit           q[$];
    logic [255:0] f;
    logic [23:0]  smp;
    for (int i = 0; i < 10; i++) q.push_back(1'b0);
    q.push_back(1'b1);
    q.push_back(1'b1);
    for (int i = 3; i >= 0; i--) q.push_back(u[i]);
    for (int c = 0; c < 8; c++) begin
      smp = s[191 - 24*c -: 24];
      for (int b = 23; b >= 0; b--) begin
        if (b % 4 == 3) q.push_back(1'b1);
        q.push_back(smp[b]);
      end
    end
    for (int i = 0; i < 256; i++) f[i] = q[i];
    return f;
  endfunction

  function automatic logic [191:0] rand192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic init_lvl(input int d);
    return (d == 1);
  endfunction

  // Model state
  logic [255:0] shq[$];
  logic [255:0] silence;
  logic [255:0] m_cur[2];
  bit           m_run[2];
  int           m_bi[2];
  logic         m_lvl[2];
  logic         obs_prev[2];
  bit           pend[2];
  int           pend_idx[2];
  int           fcount[2];
  int           tog[2];
  int           tog_prev[2];
  int           zrun[2];
  int           last_start[2];
  int           ucount[2];
  logic         cap[256];
  bit           rst_prev = 1'b0;
  bit           mon_en = 1'b0;
  int           ncyc = 0;

  logic [1:0] o_nrzi, o_tick, o_rdy, o_fs, o_urun, o_act;
  bit   tick_exp, m_ready, consumed, emit, bit0;
  logic dec;

  task automatic model_reset();
    shq.delete();
    silence = ref_frame('0, '0);
    ncyc = 0;
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 1'b0; m_bi[d] = 0; m_lvl[d] = init_lvl(d); obs_prev[d] = init_lvl(d);
      m_cur[d] = silence; pend[d] = 1'b0; fcount[d] = 0; tog[d] = 0; tog_prev[d] = 0;
      zrun[d] = 0; last_start[d] = 0; ucount[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    o_nrzi = {nrzi1, nrzi0}; o_tick = {tick1, tick0}; o_rdy = {ready1, ready0};
    o_fs   = {fs1, fs0};     o_urun = {urun1, urun0}; o_act = {act1, act0};
    if (rst_prev) model_reset();
    else ncyc++;
    rst_prev = rst;
    if (mon_en) begin
      tick_exp = (ncyc % 4 == 3);
      m_ready  = (shq.size() == 0);
      consumed = 1'b0;
      for (int d = 0; d < 2; d++) begin
        check_eq("nrzi_level", o_nrzi[d], m_lvl[d]);
        check_eq("bit_tick", o_tick[d], tick_exp);
        check_eq("frame_ready", o_rdy[d], m_ready);
        check_eq("active", o_act[d], m_run[d]);
        if (o_urun[d]) ucount[d]++;
        if (pend[d]) begin
          dec = o_nrzi[d] ^ obs_prev[d];
          tog[d] += int'(dec);
          zrun[d] = dec ? 0 : zrun[d] + 1;
          if (pend_idx[d] >= 12) check_eq("payload_zero_run", zrun[d] > 4, 0);
          if (d == 0) cap[pend_idx[0]] = dec;
          pend[d] = 1'b0;
        end
        emit = tick_exp && (m_run[d] || !m_ready);
        bit0 = emit && (m_bi[d] == 0);
        check_eq("frame_start", o_fs[d], bit0);
        check_eq("underrun", o_urun[d], bit0 && m_ready);
        if (bit0) begin
          if (fcount[d] > 0) begin
            check_eq("frame_period", ncyc - last_start[d], 1024);
            check_eq("frame_toggles", tog[d], $countones(m_cur[d]));
          end
          tog_prev[d] = tog[d]; tog[d] = 0; last_start[d] = ncyc; fcount[d]++;
          if (!m_ready) begin
            m_cur[d] = shq[0];
            consumed = 1'b1;
          end else if (d == 0) begin
            m_cur[d] = silence;
          end
          m_run[d] = 1'b1;
        end
        if (emit) begin
          m_lvl[d] = m_lvl[d] ^ m_cur[d][m_bi[d]];
          pend[d] = 1'b1;
          pend_idx[d] = m_bi[d];
          m_bi[d] = (m_bi[d] + 1) % 256;
        end
        obs_prev[d] = o_nrzi[d];
      end
      if (consumed) void'(shq.pop_front());
      if (!rst && valid && m_ready) shq.push_back(ref_frame(samples, user));
    end
  end

  task automatic send(input logic [191:0] s, input logic [3:0] u);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      if (ready0) begin
        samples = s; user = u; valid = 1'b1; done = 1'b1;
      end else begin
        samples = rand192(); user = 4'($urandom); valid = 1'b1;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; samples = rand192(); user = 4'($urandom);
    check_eq("send_accepted", done, 1);
  endtask

  task automatic wait_fc(input int target);
    for (int i = 0; i < 8000 && fcount[0] < target; i++) @(posedge clk);
    check_eq("frame_count_reached", fcount[0] >= target, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      samples = rand192(); user = 4'($urandom);
      valid = ($urandom_range(0, 3) == 0) && !ready0;
    end
    valid = 1'b0;
  endtask

  logic [33:0] exp_bits;
  logic [33:0] got_bits;
  int          base_fc;

  initial begin
    rst = 1'b1; valid = 1'b0; samples = '0; user = '0;
    repeat (3) @(posedge clk);
    #1; mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_nrzi0", nrzi0, 0);
    check_eq("rst_nrzi1", nrzi1, 1);
    check_eq("rst_ready", ready0, 1);
    check_eq("rst_active", act0, 0);
    check_eq("rst_frame_start", fs0, 0);
    check_eq("rst_underrun", urun1, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Silent frame, then the directed ch0/user frame; then starve two frames.
    send('0, 4'b0000);
    send({24'hABCDEF, 168'h0}, 4'b1010);
    wait_fc(2);
    check_eq("zero_frame_toggles", tog_prev[0], 50);
    wait_fc(3);
    exp_bits = 34'b1010_1_1010_1_1011_1_1100_1_1101_1_1110_1_1111;
    got_bits = '0;
    for (int i = 12; i <= 45; i++) got_bits = {got_bits[32:0], cap[i]};
    check_eq("directed_bits_12_45", got_bits, exp_bits);
    wait_fc(4);
    check_eq("underruns_silence", ucount[0], 2);
    check_eq("underruns_repeat", ucount[1], 2);

    // Random payloads with random gaps, some long enough to starve a frame.
    for (int k = 0; k < 14; k++) begin
      idle_cycles(($urandom_range(0, 5) == 0) ? 1100 : $urandom_range(0, 60));
      send(rand192(), 4'($urandom));
    end

    // Withhold the handshake for a few frames.
    base_fc = fcount[0];
    wait_fc(base_fc + 3);

    // Reset in the middle of a frame.
    for (int i = 0; i < 2000 && !(m_run[0] && m_bi[0] == 137); i++) @(posedge clk);
    check_eq("reached_bit_137", m_bi[0], 137);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_nrzi0", nrzi0, 0);
    check_eq("midrst_nrzi1", nrzi1, 1);
    check_eq("midrst_ready", ready0, 1);
    check_eq("midrst_active", act1, 0);
    send(rand192(), 4'($urandom));
    wait_fc(2);
    repeat (8) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
